// File: rtl/mem_lsu_if.sv
// Request/response and dmem bus bundle for the MEM-stage load/store unit.
// master = pipeline + dmem side, slave = mem_lsu.
interface mem_lsu_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_store;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          stall;
  logic [31:0]   load_data;
  logic          load_valid;
  logic          err;
  logic          dmem_we;
  logic [AW-1:0] dmem_a;
  logic [31:0]   dmem_wd;
  logic [31:0]   dmem_rd;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, dmem_rd,
    input  stall, load_data, load_valid, err, dmem_we, dmem_a, dmem_wd
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, dmem_rd,
    output stall, load_data, load_valid, err, dmem_we, dmem_a, dmem_wd
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte/half/word accesses onto a word-only dmem.
// Sub-word stores use a two-cycle read-modify-write; misaligned requests raise err.
module mem_lsu #(
  parameter int AW = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_lsu_if.slave bus
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t        state, state_nx;
  logic [1:0]    lane;
  logic [AW-1:0] waddr;
  logic          misal;
  logic          accept;
  logic          is_load;
  logic          is_wst;
  logic          is_sst;
  logic [AW-1:0] addr_p1;
  logic [31:0]   merged_p1;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] ln,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] ln, input logic [1:0] size);
    store_merge = w;
    if (size == 2'b00)
      store_merge[{ln, 3'b000} +: 8] = wd[7:0];
    else if (ln[1])
      store_merge[31:16] = wd[15:0];
    else
      store_merge[15:0] = wd[15:0];
  endfunction

  assign lane  = bus.req_addr[1:0];
  assign waddr = {bus.req_addr[AW-1:2], 2'b00};

  always_comb begin
    case (bus.req_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = lane[0];
      2'b10:   misal = |lane;
      default: misal = 1'b1;
    endcase
  end

  // Requests are only taken in IDLE; during RMW_WR the held request is the one being written.
  assign accept  = bus.req_valid && !misal && (state == IDLE);
  assign is_load = accept && !bus.req_store;
  assign is_wst  = accept && bus.req_store && (bus.req_size == 2'b10);
  assign is_sst  = accept && bus.req_store && (bus.req_size != 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.stall   = 1'b0;
    bus.dmem_we = 1'b0;
    bus.dmem_a  = waddr;
    bus.dmem_wd = bus.req_wdata;
    case (state)
      IDLE: begin
        if (is_wst) bus.dmem_we = 1'b1;
        if (is_sst) begin
          bus.stall = 1'b1;
          state_nx  = RMW_WR;
        end
      end
      RMW_WR: begin
        bus.dmem_we = 1'b1;
        bus.dmem_a  = addr_p1;
        bus.dmem_wd = merged_p1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset must kill an in-flight RMW write before the next edge.
    if (!rst_n) begin
      bus.dmem_we = 1'b0;
      bus.stall   = 1'b0;
    end
  end

  // Read stage -> write stage: merged word and its address for the RMW write cycle
  always_ff @(posedge clk) begin
    if (is_sst) begin
      addr_p1   <= waddr;
      merged_p1 <= store_merge(bus.dmem_rd, bus.req_wdata, lane, bus.req_size);
    end
  end

  // Load/err result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.load_data  <= 32'd0;
      bus.load_valid <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.load_valid <= is_load;
      bus.err        <= bus.req_valid && misal && (state == IDLE);
      if (is_load)
        bus.load_data <= load_extend(bus.dmem_rd, lane, bus.req_size, bus.req_unsigned);
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-array reference memory, per-cycle compare process,
// directed scenarios with literal expectations plus a randomized request stream.
module tb_mem_lsu;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_lsu_if #(.AW(AW)) bus ();
  mem_lsu #(.AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Word-only data memory, 64 bytes, combinational read
  logic [31:0] dmem [16] = '{default: 32'd0};
  assign bus.dmem_rd = dmem[bus.dmem_a[5:2]];
  always @(posedge clk) if (bus.dmem_we) dmem[bus.dmem_a[5:2]] <= bus.dmem_wd;

  // Reference model: byte-addressed memory
  logic [7:0] ref_b [64];

  int checks = 0;
  int errors = 0;
  bit run;

  logic        exp_stall, exp_we, chk_a, exp_lv, exp_err;
  logic [31:0] exp_a, exp_wd, exp_ld;
  logic        nxt_lv, nxt_err, nxt_lit_en;
  logic [31:0] nxt_ld, nxt_lit_val;
  logic        lit_ld_en, lit_wd_en;
  logic [31:0] lit_ld_val, lit_wd_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_load_valid", 32'(bus.load_valid), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_load_data", bus.load_data, 32'd0);
    end else if (run) begin
      chk("stall", 32'(bus.stall), 32'(exp_stall));
      chk("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
      if (chk_a) chk("dmem_a", bus.dmem_a, exp_a);
      if (exp_we) chk("dmem_wd", bus.dmem_wd, exp_wd);
      chk("load_valid", 32'(bus.load_valid), 32'(exp_lv));
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("load_data", bus.load_data, exp_ld);
      if (lit_ld_en) chk("lit_load", bus.load_data, lit_ld_val);
      if (lit_wd_en) chk("lit_wdata", bus.dmem_wd, lit_wd_val);
    end
  end

  function automatic bit mis(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] mword(input int wa);
    return {ref_b[wa+3], ref_b[wa+2], ref_b[wa+1], ref_b[wa]};
  endfunction

  function automatic logic [31:0] mload(input int a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = {24'd0, ref_b[a]};
        if (!uns && ref_b[a][7]) v[31:8] = '1;
      end
      2'd1: begin
        v = {16'd0, ref_b[a+1], ref_b[a]};
        if (!uns && ref_b[a+1][7]) v[31:16] = '1;
      end
      default: v = mword(a);
    endcase
    return v;
  endfunction

  task automatic mstore(input int a, input logic [1:0] sz, input logic [31:0] wd);
    ref_b[a] = wd[7:0];
    if (sz != 2'd0) ref_b[a+1] = wd[15:8];
    if (sz == 2'd2) begin
      ref_b[a+2] = wd[23:16];
      ref_b[a+3] = wd[31:24];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_lv  = nxt_lv;
    exp_err = nxt_err;
    if (nxt_lv) exp_ld = nxt_ld;
    lit_ld_en  = nxt_lit_en;
    lit_ld_val = nxt_lit_val;
    nxt_lv = 1'b0; nxt_err = 1'b0; nxt_lit_en = 1'b0;
    exp_stall = 1'b0; exp_we = 1'b0; chk_a = 1'b0; lit_wd_en = 1'b0;
  endtask

  task automatic idle();
    step();
    bus.req_valid    = 1'b0;
    bus.req_store    = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = AW'($urandom_range(0, 63));
    bus.req_wdata    = $urandom;
  endtask

  task automatic do_req(input bit st, input logic [1:0] sz, input bit uns, input int addr,
                        input logic [31:0] wd, input bit le = 1'b0, input logic [31:0] lv = 32'd0);
    int wa;
    wa = addr - (addr % 4);
    step();
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = AW'(addr);
    bus.req_wdata    = wd;
    if (mis(sz, addr)) begin
      nxt_err = 1'b1;
    end else if (!st) begin
      chk_a = 1'b1; exp_a = 32'(wa);
      nxt_lv = 1'b1; nxt_ld = mload(addr, sz, uns);
      nxt_lit_en = le; nxt_lit_val = lv;
    end else if (sz == 2'd2) begin
      exp_we = 1'b1; chk_a = 1'b1; exp_a = 32'(wa); exp_wd = wd;
      lit_wd_en = le; lit_wd_val = lv;
      mstore(addr, sz, wd);
    end else begin
      exp_stall = 1'b1; chk_a = 1'b1; exp_a = 32'(wa);
      mstore(addr, sz, wd);
      step();
      exp_we = 1'b1; chk_a = 1'b1; exp_a = 32'(wa); exp_wd = mword(wa);
      lit_wd_en = le; lit_wd_val = lv;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  sv [4];
    int          a;
    logic [1:0]  sz;
    rst_n = 1'b0;
    run   = 1'b0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'd0;
    exp_stall = 0; exp_we = 0; chk_a = 0; exp_lv = 0; exp_err = 0;
    exp_a = 0; exp_wd = 0; exp_ld = 0;
    nxt_lv = 0; nxt_err = 0; nxt_lit_en = 0; nxt_ld = 0; nxt_lit_val = 0;
    lit_ld_en = 0; lit_wd_en = 0; lit_ld_val = 0; lit_wd_val = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    run   = 1'b1;

    // Word store and load-back
    do_req(1, 2'd2, 0, 4, 32'hAA55AA55, 1, 32'hAA55AA55);
    do_req(0, 2'd2, 0, 4, 32'h0, 1, 32'hAA55AA55);
    // Byte store RMW, then load of the updated word
    do_req(1, 2'd0, 0, 5, 32'h000000CC, 1, 32'hAA55CC55);
    do_req(0, 2'd2, 0, 4, 32'h0, 1, 32'hAA55CC55);
    // Halfword store into upper half, signed/unsigned half loads
    do_req(1, 2'd2, 0, 8, 32'h12345678);
    do_req(1, 2'd1, 0, 10, 32'h0000BEEF, 1, 32'hBEEF5678);
    do_req(0, 2'd1, 1, 10, 32'h0, 1, 32'h0000BEEF);
    do_req(0, 2'd1, 0, 10, 32'h0, 1, 32'hFFFFBEEF);
    // Byte lane selection and extension
    do_req(1, 2'd2, 0, 12, 32'h8000807F);
    do_req(0, 2'd0, 0, 12, 32'h0, 1, 32'h0000007F);
    do_req(0, 2'd0, 0, 13, 32'h0, 1, 32'hFFFFFF80);
    do_req(0, 2'd0, 1, 13, 32'h0, 1, 32'h00000080);
    do_req(0, 2'd0, 0, 15, 32'h0, 1, 32'hFFFFFF80);
    // Misaligned and illegal-size requests
    do_req(0, 2'd1, 0, 5, 32'h0);
    do_req(1, 2'd2, 0, 6, 32'hDEADBEEF);
    do_req(0, 2'd3, 0, 0, 32'h0);
    do_req(0, 2'd2, 0, 4, 32'h0, 1, 32'hAA55CC55);
    idle();

    // Reset during the RMW write cycle: write must be lost
    step();
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = AW'(4); bus.req_wdata = 32'h00000011;
    exp_stall = 1'b1; chk_a = 1'b1; exp_a = 32'd4;
    step();
    for (int i = 0; i < 4; i++) sv[i] = ref_b[4+i];
    mstore(4, 2'd0, 32'h00000011);
    w = mword(4);
    for (int i = 0; i < 4; i++) ref_b[4+i] = sv[i];
    exp_we = 1'b1; chk_a = 1'b1; exp_a = 32'd4; exp_wd = w;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    exp_we = 0; chk_a = 0; exp_stall = 0; exp_lv = 0; exp_err = 0; exp_ld = 0;
    nxt_lv = 0; nxt_err = 0; nxt_lit_en = 0; lit_wd_en = 0; lit_ld_en = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle();
    do_req(0, 2'd2, 0, 4, 32'h0, 1, 32'hAA55CC55);

    // Randomized traffic against the byte-array model
    for (int n = 0; n < 400; n++) begin
      a  = $urandom_range(0, 63);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a - (a % (1 << sz));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end

    // Read back every word
    for (int i = 0; i < 16; i++) do_req(0, 2'd2, 0, i * 4, 32'h0);
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit for the pipeline MEM stage, directly upstream of dmem.
- Converts byte, halfword and word load/store requests into dmem's word-only interface.
- Loads: selects the addressed lane, then sign- or zero-extends it.
- Sub-word stores: read-modify-write, because dmem has only a whole-word write enable.
- Flags misaligned or illegal-size accesses and suppresses them.

Parameters:
- AW, 32, address width of req_addr and dmem_a (data path fixed at 32 bits).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present this cycle
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  upstream holds request stable and does not advance
- load_data  out  32  registered, extended load result
- load_valid  out  1  one-cycle pulse; load_data updated
- err  out  1  one-cycle pulse; misaligned or illegal request dropped
- dmem_we  out  1  dmem write enable
- dmem_a  out  AW  dmem address, always word-aligned ({addr[AW-1:2],2'b00})
- dmem_wd  out  32  dmem write data
- dmem_rd  in  32  dmem read data, combinational from dmem_a

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; load_data = 0; load_valid = 0; err = 0.
  - dmem_we = 0 and stall = 0 while rst_n is low.
- Little-endian lanes:
  - Byte n occupies bits [8n+7:8n], n = addr[1:0].
  - Half occupies bits [16h+15:16h], h = addr[1].
- Misaligned access: half with addr[0]=1; word with addr[1:0]≠0; any size 11.
  - Next cycle: err = 1 for one cycle.
  - No dmem write, no load_valid, no stall.
- FSM states IDLE, RMW_WR.
- IDLE, no req_valid: dmem_we = 0, stall = 0.
- IDLE, aligned load:
  - dmem_a = word address.
  - Lane extracted from dmem_rd, extended per req_unsigned (word: unchanged).
  - Result registered: load_data/load_valid appear on the next cycle.
  - stall = 0; latency 1.
  - load_data holds its value until the next load completes.
- IDLE, aligned word store:
  - Same cycle: dmem_we = 1, dmem_wd = req_wdata.
  - stall = 0; write commits at this edge.
- IDLE, aligned byte/half store:
  - stall = 1; dmem_we = 0; dmem_a = word address.
  - Register merged word: dmem_rd with the target lane replaced by req_wdata[7:0] or [15:0].
  - Register word address; go to RMW_WR.
- RMW_WR:
  - dmem_we = 1; dmem_a = registered address; dmem_wd = merged word.
  - stall = 0; request inputs ignored this cycle (the same request is still presented).
  - Request retires at the edge; return to IDLE.
  - Sub-word store occupies 2 cycles total, with 1 stall cycle.
- dmem_we is only ever 1 in IDLE (word store) or RMW_WR.
- Reset mid-RMW: dmem_we drops immediately; pending write is lost; memory word unchanged.
- load_valid and err are never both high.
- Back-to-back requests are supported:
  - A load immediately after an RMW reads the updated word, since dmem has committed it.
  - No forwarding is required.

Test Plan:
1. Reset, then SW addr 4 data AA55AA55 → same cycle dmem_we=1, dmem_a=4, dmem_wd=AA55AA55, stall=0; LW addr 4 → next cycle load_valid=1, load_data=AA55AA55.
2. SB addr 5 wdata 000000CC over AA55AA55 → cycle 1 stall=1, we=0; cycle 2 we=1, a=4, wd=AA55CC55; following LW addr 4 → AA55CC55.
3. SH addr 10 wdata 0000BEEF over 12345678 at addr 8 → write BEEF5678; LHU addr 10 → 0000BEEF; LH addr 10 → FFFFBEEF.
4. Word 8000807F at addr 12: LB addr 12 → 0000007F; LB addr 13 → FFFFFF80; LBU addr 13 → 00000080; LB addr 15 → FFFFFF80.
5. LH addr 5, SW addr 6, LW size 11 addr 0 → err pulse each, no load_valid, dmem_we never 1; memory contents unchanged on read-back.
6. SB addr 4 accepted, rst_n pulled low during RMW_WR → dmem_we=0 immediately, state IDLE after release, word at 4 unchanged, load_data=0.
